// File: rtl/mandel_pkg.sv
// mandel_pkg: shared FSM states, pixel tags and palette for the Mandelbrot stream path
package mandel_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic sof;
    logic eol;
  } tag_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [23:0] palette(input logic [7:0] c, input logic mode);
    return mode ? {c, c[6:0], 1'b0, c[5:0], 2'b00} : {3{8'hFF - c}};
  endfunction
endpackage

// File: rtl/mandel_colour_map.sv
// mandel_colour_map: combinational depth to RGB mapping with shift, saturation and palette select
module mandel_colour_map
  import mandel_pkg::*;
#(
  parameter int DEPTH_W = 11
) (
  input  logic [DEPTH_W-1:0] depth,
  input  logic [DEPTH_W-1:0] max_iter,
  input  logic [3:0]         shift,
  input  logic               mode,
  output logic [23:0]        rgb
);
  logic [DEPTH_W-1:0] scaled;
  logic [7:0] c;
  always_comb begin
    scaled = depth >> shift;
    c = (depth >= max_iter || scaled > DEPTH_W'(255)) ? 8'hFF : scaled[7:0];
    rgb = palette(c, mode);
  end
endmodule

// File: rtl/mandel_stream_scheduler.sv
// mandel_stream_scheduler: round-robin pixel dispatch to depth engines with in-order
// collection, colouring and AXI4-Stream output
module mandel_stream_scheduler
  import mandel_pkg::*;
#(
  parameter int X_SIZE = 960,
  parameter int Y_SIZE = 720,
  parameter int NUM_ENGINES = 4,
  parameter int DEPTH_W = 11,
  localparam int XW = $clog2(X_SIZE),
  localparam int YW = $clog2(Y_SIZE)
) (
  input  logic                           out_stream_aclk,
  input  logic                           periph_resetn,
  input  logic                           cfg_enable,
  input  logic [DEPTH_W-1:0]             cfg_max_iter,
  input  logic [3:0]                     cfg_shift,
  input  logic                           cfg_mode,
  output logic [NUM_ENGINES-1:0]         eng_start,
  output logic [XW-1:0]                  eng_x,
  output logic [YW-1:0]                  eng_y,
  input  logic [NUM_ENGINES-1:0]         eng_done,
  input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
  output logic [31:0]                    out_stream_tdata,
  output logic [3:0]                     out_stream_tkeep,
  output logic                           out_stream_tvalid,
  input  logic                           out_stream_tready,
  output logic                           out_stream_tlast,
  output logic                           out_stream_tuser,
  output logic                           frame_done,
  output logic                           busy,
  output logic                           err_unexpected_done
);
  localparam int EW = idx_w(NUM_ENGINES);
  state_t state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [EW-1:0] issue_ptr, out_ptr;
  logic [NUM_ENGINES-1:0] eng_busy, slot_full, retire, issue_mask, load_mask;
  logic [DEPTH_W-1:0] slot_depth [NUM_ENGINES];
  tag_t slot_tag [NUM_ENGINES];
  logic [DEPTH_W-1:0] sh_max_iter;
  logic [3:0] sh_shift;
  logic sh_mode, issue, load, x_last, y_last, drain_done;
  logic [23:0] rgb;

  assign out_stream_tkeep = 4'hF;
  assign busy = state != IDLE;

  mandel_colour_map #(.DEPTH_W(DEPTH_W)) u_colour (
    .depth(slot_depth[out_ptr]),
    .max_iter(sh_max_iter),
    .shift(sh_shift),
    .mode(sh_mode),
    .rgb(rgb)
  );

  always_comb begin
    x_last = x == XW'(X_SIZE - 1);
    y_last = y == YW'(Y_SIZE - 1);
    issue = state == RUN && !eng_busy[issue_ptr] && !slot_full[issue_ptr];
    load = slot_full[out_ptr] && (!out_stream_tvalid || out_stream_tready);
    retire = eng_done & eng_busy;
    issue_mask = issue ? NUM_ENGINES'(1) << issue_ptr : '0;
    load_mask = load ? NUM_ENGINES'(1) << out_ptr : '0;
    // with nothing in engines or slots, the beat leaving now must be the frame's last
    drain_done = state == DRAIN && out_stream_tvalid && out_stream_tready && !(|eng_busy) && !(|slot_full);
    state_nx = state;
    case (state)
      IDLE:    state_nx = cfg_enable ? RUN : IDLE;
      RUN:     state_nx = (issue && x_last && y_last) ? DRAIN : RUN;
      DRAIN:   state_nx = drain_done ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn)
    if (!periph_resetn) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge out_stream_aclk or negedge periph_resetn)
    if (!periph_resetn) begin
      x <= '0;
      y <= '0;
      issue_ptr <= '0;
      out_ptr <= '0;
      eng_busy <= '0;
      slot_full <= '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        slot_depth[i] <= '0;
        slot_tag[i] <= '0;
      end
      sh_max_iter <= '0;
      sh_shift <= '0;
      sh_mode <= 1'b0;
      eng_start <= '0;
      eng_x <= '0;
      eng_y <= '0;
      out_stream_tdata <= '0;
      out_stream_tvalid <= 1'b0;
      out_stream_tlast <= 1'b0;
      out_stream_tuser <= 1'b0;
      frame_done <= 1'b0;
      err_unexpected_done <= 1'b0;
    end else begin
      frame_done <= drain_done;
      if (state == IDLE && cfg_enable) begin
        sh_max_iter <= cfg_max_iter;
        sh_shift <= cfg_shift;
        sh_mode <= cfg_mode;
      end
      eng_start <= issue_mask;
      if (issue) begin
        eng_x <= x;
        eng_y <= y;
        slot_tag[issue_ptr] <= '{sof: x == '0 && y == '0, eol: x_last};
        x <= x_last ? '0 : x + 1'b1;
        if (x_last) y <= y_last ? '0 : y + 1'b1;
        issue_ptr <= issue_ptr == EW'(NUM_ENGINES - 1) ? '0 : issue_ptr + 1'b1;
      end
      for (int i = 0; i < NUM_ENGINES; i++)
        if (retire[i]) slot_depth[i] <= eng_depth[i*DEPTH_W +: DEPTH_W];
      eng_busy <= (eng_busy | issue_mask) & ~retire;
      slot_full <= (slot_full | retire) & ~load_mask;
      err_unexpected_done <= err_unexpected_done | (|(eng_done & ~eng_busy));
      if (load) begin
        out_stream_tvalid <= 1'b1;
        out_stream_tdata <= {8'h00, rgb};
        out_stream_tlast <= slot_tag[out_ptr].eol;
        out_stream_tuser <= slot_tag[out_ptr].sof;
        out_ptr <= out_ptr == EW'(NUM_ENGINES - 1) ? '0 : out_ptr + 1'b1;
      end else if (out_stream_tready) out_stream_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_mandel_stream_scheduler.sv
// tb_mandel_stream_scheduler: randomized engine/sink models with a raster-order scoreboard
module tb_mandel_stream_scheduler;
  localparam int X = 4, Y = 2, N = 2, DW = 11, P = X * Y;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_enable = 1'b0, cfg_mode = 1'b0;
  logic [DW-1:0] cfg_max_iter = '0;
  logic [3:0] cfg_shift = '0;
  logic [N-1:0] eng_start, eng_done = '0;
  logic [1:0] eng_x;
  logic [0:0] eng_y;
  logic [N*DW-1:0] eng_depth = '0;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  logic tvalid, tready = 1'b0, tlast, tuser, frame_done, busy, err;

  always #5 clk = ~clk;

  mandel_stream_scheduler #(.X_SIZE(X), .Y_SIZE(Y), .NUM_ENGINES(N), .DEPTH_W(DW)) dut (
    .out_stream_aclk(clk), .periph_resetn(rst_n), .cfg_enable(cfg_enable),
    .cfg_max_iter(cfg_max_iter), .cfg_shift(cfg_shift), .cfg_mode(cfg_mode),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_done(eng_done),
    .eng_depth(eng_depth), .out_stream_tdata(tdata), .out_stream_tkeep(tkeep),
    .out_stream_tvalid(tvalid), .out_stream_tready(tready), .out_stream_tlast(tlast),
    .out_stream_tuser(tuser), .frame_done(frame_done), .busy(busy),
    .err_unexpected_done(err)
  );

  int dep [P];
  int lat [N];
  int cnt [N];
  int px [N];
  int py [N];
  bit pend [N];
  int rdy_mode, spur_fired, fd_cnt, starts, accepts, infl_max, stall_bad, cyc;
  bit spur_req, stall_prev;
  logic [33:0] held;
  logic [33:0] beats [$];
  int passed = 0, total = 0;

  // engines, sink and monitor all act on the falling edge, away from the DUT's sampling edge
  always @(negedge clk) begin
    logic [N-1:0] d;
    d = '0;
    cyc++;
    tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    if (!rst_n) begin
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (spur_req && !pend[1] && !eng_start[1]) begin
        d[1] = 1'b1;
        spur_req = 1'b0;
        spur_fired++;
      end
      for (int i = 0; i < N; i++)
        if (eng_start[i]) begin
          pend[i] = 1'b1;
          cnt[i] = lat[i];
          px[i] = int'(eng_x);
          py[i] = int'(eng_y);
        end else if (pend[i]) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            d[i] = 1'b1;
            eng_depth[i*DW +: DW] = DW'(dep[py[i] * X + px[i]]);
            pend[i] = 1'b0;
          end
        end
      starts += $countones(eng_start);
      if (stall_prev && !(tvalid && {tuser, tlast, tdata} == held)) stall_bad++;
      stall_prev = tvalid && !tready;
      held = {tuser, tlast, tdata};
      if (tvalid && tready) begin
        beats.push_back(held);
        accepts++;
      end
      if (frame_done) fd_cnt++;
      if (starts - accepts > infl_max) infl_max = starts - accepts;
    end
    eng_done = d;
  end

  function automatic logic [33:0] expect_beat(input int k, input int mi, input int sh, input bit md);
    int c;
    logic [7:0] r, g, b;
    c = dep[k] >= mi ? 255 : ((dep[k] >> sh) > 255 ? 255 : dep[k] >> sh);
    if (md) begin
      r = 8'(c);
      g = 8'((c * 2) % 256);
      b = 8'((c * 4) % 256);
    end else begin
      r = 8'(255 - c);
      g = r;
      b = r;
    end
    return {k == 0, k % X == X - 1, 8'h00, r, g, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic fill_raster();
    for (int k = 0; k < P; k++) dep[k] = (k % X) + 4 * (k / X);
  endtask

  task automatic fill_random();
    for (int k = 0; k < P; k++) dep[k] = int'($urandom_range(0, 2047));
  endtask

  task automatic run_frame(input string nm, input int l0, input int l1, input int rm,
                           input int mi, input int sh, input bit md, input bit spur);
    beats.delete();
    fd_cnt = 0; starts = 0; accepts = 0; infl_max = 0; stall_bad = 0;
    lat[0] = l0; lat[1] = l1; rdy_mode = rm;
    @(negedge clk);
    cfg_max_iter = DW'(mi); cfg_shift = 4'(sh); cfg_mode = md; cfg_enable = 1'b1;
    for (int t = 0; t < 20 && !busy; t++) @(negedge clk);
    check({nm, " busy at start"}, 64'(busy), 64'd1);
    // scramble config mid-frame: the latched copy must govern the whole frame
    cfg_enable = 1'b0;
    cfg_max_iter = DW'($urandom); cfg_shift = 4'($urandom); cfg_mode = 1'($urandom);
    if (spur) begin
      repeat (4) @(negedge clk);
      spur_req = 1'b1;
    end
    for (int t = 0; t < 4000 && fd_cnt == 0; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    check({nm, " frame_done pulses"}, 64'(fd_cnt), 64'd1);
    check({nm, " busy after"}, 64'(busy), 64'd0);
    check({nm, " beat count"}, 64'(beats.size()), 64'(P));
    for (int k = 0; k < P; k++)
      check($sformatf("%s beat%0d", nm, k), k < beats.size() ? 64'(beats[k]) : 64'hx,
            64'(expect_beat(k, mi, sh, md)));
    check({nm, " stall stability"}, 64'(stall_bad), 64'd0);
    check({nm, " inflight bound"}, 64'(infl_max <= N + 1), 64'd1);
  endtask

  initial begin
    fill_raster();
    lat[0] = 1; lat[1] = 1;
    repeat (3) @(negedge clk);
    check("reset tvalid", 64'(tvalid), 0);
    check("reset tdata", 64'(tdata), 0);
    check("reset tlast", 64'(tlast), 0);
    check("reset tuser", 64'(tuser), 0);
    check("reset eng_start", 64'(eng_start), 0);
    check("reset frame_done", 64'(frame_done), 0);
    check("reset busy", 64'(busy), 0);
    check("reset err", 64'(err), 0);
    check("tkeep", 64'(tkeep), 64'hF);
    rst_n = 1'b1;

    fill_raster();
    run_frame("A", 3, 3, 0, 256, 0, 1'b0, 1'b0);
    check("A no error", 64'(err), 0);

    fill_raster();
    run_frame("B", 9, 1, 0, 256, 0, 1'b1, 1'b0);

    fill_random();
    run_frame("C", 1, 1, 1, int'($urandom_range(0, 2047)), int'($urandom_range(0, 15)), 1'($urandom), 1'b0);
    check("C slots fill under backpressure", 64'(infl_max), 64'(N + 1));

    dep = '{300, 100, 0, 255, 256, 511, 1000, 2047};
    run_frame("D", 2, 3, 0, 256, 1, 1'b0, 1'b0);
    check("D depth300", 64'(beats[0][31:0]), 64'h00000000);
    check("D depth100", 64'(beats[1][31:0]), 64'h00CDCDCD);
    check("D depth0", 64'(beats[2][31:0]), 64'h00FFFFFF);

    fill_random();
    dep[0] = 100;
    run_frame("E", 2, 2, 2, 256, 1, 1'b1, 1'b0);
    check("E mode1 depth100", 64'(beats[0][31:0]), 64'h003264C8);

    fill_random();
    run_frame("F", int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 2,
              int'($urandom_range(0, 2047)), int'($urandom_range(0, 15)), 1'($urandom), 1'b1);
    check("F spurious injected", 64'(spur_fired), 64'd1);
    check("F err set", 64'(err), 64'd1);

    fill_random();
    run_frame("G", int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 2,
              int'($urandom_range(0, 2047)), int'($urandom_range(0, 15)), 1'($urandom), 1'b0);
    check("G err sticky", 64'(err), 64'd1);

    fill_raster();
    lat[0] = 2; lat[1] = 2; rdy_mode = 0;
    @(negedge clk);
    cfg_enable = 1'b1;
    repeat (5) @(negedge clk);
    cfg_enable = 1'b0;
    check("H mid-frame busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("H async tvalid", 64'(tvalid), 0);
    check("H async tdata", 64'(tdata), 0);
    check("H async tlast", 64'(tlast), 0);
    check("H async tuser", 64'(tuser), 0);
    check("H async eng_start", 64'(eng_start), 0);
    check("H async busy", 64'(busy), 0);
    check("H async err", 64'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    run_frame("H", int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 2,
              int'($urandom_range(0, 2047)), int'($urandom_range(0, 15)), 1'($urandom), 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mandel_stream_scheduler.md
Name: mandel_stream_scheduler

Overview:
Parametrised successor to the single-engine pixel generator. It scans a frame of X_SIZE by Y_SIZE pixels and dispatches coordinates round-robin to NUM_ENGINES external depth engines. Results are collected back in raster order, mapped to RGB through a selectable palette, and emitted directly as a 32-bit AXI4-Stream with SOF (tuser) and EOL (tlast). It sits between the pixel_to_complex/depth_calculator farm and the video DMA, replacing the packer path for multi-engine builds.

Parameters:
X_SIZE, 960, pixels per line
Y_SIZE, 720, lines per frame
NUM_ENGINES, 4, depth engines served (>=1)
DEPTH_W, 11, engine depth result width
XW, $clog2(X_SIZE), x coordinate width (localparam)
YW, $clog2(Y_SIZE), y coordinate width (localparam)

Ports:
out_stream_aclk  in  1  sole clock
periph_resetn  in  1  asynchronous active-low reset
cfg_enable  in  1  run frames; sampled only at frame start
cfg_max_iter  in  DEPTH_W  iteration limit for colouring
cfg_shift  in  4  right-shift applied to depth before colouring
cfg_mode  in  1  0 = inverted greyscale, 1 = banded false colour
eng_start  out  NUM_ENGINES  one-cycle start pulse per engine
eng_x  out  XW  pixel x for the engine being started
eng_y  out  YW  pixel y for the engine being started
eng_done  in  NUM_ENGINES  one-cycle completion pulse per engine
eng_depth  in  NUM_ENGINES*DEPTH_W  flattened depths; engine i at [i*DEPTH_W +: DEPTH_W]
out_stream_tdata  out  32  {8'h00,r,g,b}
out_stream_tkeep  out  4  constant 4'hF
out_stream_tvalid  out  1  pixel valid
out_stream_tready  in  1  sink ready
out_stream_tlast  out  1  last pixel of line
out_stream_tuser  out  1  first pixel of frame
frame_done  out  1  one-cycle pulse when the last frame pixel is accepted
busy  out  1  frame in progress
err_unexpected_done  out  1  sticky; done pulse seen from an idle engine

Behaviour:
- Reset (async assert, sync release): x=y=0, issue_ptr=out_ptr=0, all eng_busy/slot_full=0. eng_start=0, tvalid=0, tdata=0, tlast=0, tuser=0, frame_done=0, busy=0, err=0.
- Frame start: in IDLE with cfg_enable=1, latch cfg_max_iter/shift/mode into shadow registers and go to RUN (busy=1). Config changes mid-frame have no effect until the next frame.
- States:
  - IDLE → RUN: cfg_enable=1.
  - RUN → DRAIN: last pixel (X_SIZE-1, Y_SIZE-1) issued.
  - DRAIN → IDLE: the last pixel's beat is accepted. frame_done pulses in that cycle, registered and visible the next cycle.
  - Deasserting cfg_enable mid-frame completes the current frame.
- Issue (RUN): engine issue_ptr is free when !eng_busy[i] && !slot_full[i].
  - When free: register eng_start[issue_ptr]=1 for exactly one cycle with eng_x/eng_y, set eng_busy and store tag sof=(x==0&&y==0), eol=(x==X_SIZE-1).
  - Then advance x (wrap to 0 and increment y at X_SIZE-1; y wraps at Y_SIZE-1) and issue_ptr modulo NUM_ENGINES.
  - At most one issue per cycle. When not free, stall; no skipping, which preserves raster order.
- Retire: eng_done[i] with eng_busy[i] captures eng_depth slice into slot i, sets slot_full, clears eng_busy. Multiple simultaneous dones are all captured. eng_done[i] while !eng_busy[i] is ignored and sets err_unexpected_done.
- Output:
  - When slot_full[out_ptr] and (!tvalid || tready): load the output register with colour and tags, clear the slot, advance out_ptr.
  - Slot-full to tvalid latency is 1 cycle. Sustains 1 beat/cycle when slots are ready.
  - tdata/tlast/tuser stay stable while tvalid && !tready.
  - A retire into a slot and the output clearing a different slot in the same cycle are independent.
- Colour:
  - c = (depth >= max_iter) ? 8'hFF : saturate8(depth >> shift).
  - Mode 0: r=g=b = 8'hFF - c.
  - Mode 1: r = c, g = {c[6:0],1'b0}, b = {c[5:0],2'b00} (truncating).

Decomposition:
- Package mandel_pkg: state enum (IDLE/RUN/DRAIN), pixel tag struct {sof, eol}, colour function, engine index width localparam.
- One natural sub-module: mandel_colour_map (combinational depth→RGB with mode/shift/max_iter), reused by the legacy single-engine path.

Test Plan:
- X_SIZE=4, Y_SIZE=2, NUM_ENGINES=2, engines reply after fixed 3 cycles, tready=1 → 8 beats in raster order; tuser only on beat 0; tlast on beats 3 and 7; frame_done pulses once; busy drops afterwards.
- Engines with out-of-order latencies (engine 1 replies in 1 cycle, engine 0 in 9) → output still ordered (0,0),(1,0),(2,0)…, confirmed via a depth = x+4y engine model.
- tready toggling 1 cycle on, 2 off → no beat lost or duplicated; tdata stable while stalled; issue stalls once all slots are full.
- Colour: max_iter=256, shift=1, mode 0: depth 300 → 8'h00; depth 100 → 8'hCD; depth 0 → 8'hFF. Mode 1, depth 100 (c=50) → r=8'h32, g=8'h64, b=8'hC8.
- Spurious eng_done[1] with engine 1 idle → err_unexpected_done=1 and stays set; stream unaffected.
- periph_resetn asserted mid-frame → all outputs 0 asynchronously. After release with cfg_enable=1, the next frame starts at (0,0) with tuser on its first beat.
